// File: rtl/boot_loader_pkg.sv
// Shared types for the streaming boot loader: FSM state encoding and error codes.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

endpackage

// File: rtl/boot_word_packer.sv
// Packs little-endian IN_W beats into DATA_W words; word_valid pulses combinationally
// in the cycle the last beat of a word is accepted.
module boot_word_packer #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [IN_W-1:0]   beat_data,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam int BEATS = DATA_W / IN_W;

    generate
        if (BEATS == 1) begin : g_passthru
            assign word_valid = beat_valid;
            assign word       = beat_data;
        end else begin : g_pack
            localparam int CNT_W = $clog2(BEATS);
            localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic [DATA_W-IN_W-1:0] low_q, low_d;
            logic                   last;

            assign last       = (cnt_q == LAST_BEAT);
            assign word_valid = beat_valid & last;
            // The final beat bypasses the register so the word is usable in its arrival cycle.
            assign word       = {beat_data, low_q};

            always_comb begin
                cnt_d = cnt_q;
                low_d = low_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (beat_valid) begin
                    cnt_d = last ? '0 : cnt_q + CNT_W'(1);
                    for (int i = 0; i < BEATS - 1; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            low_d[i*IN_W +: IN_W] = beat_data;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    low_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    low_q <= low_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/boot_stream_loader.sv
// Streams a framed image (length, payload, checksum) into instruction memory through
// the boot write port, then releases the CPU only if the whole image checked out.
module boot_stream_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IN_W      = 8,
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_ready,
    output logic              boot_up,
    output logic              boot_web,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [DATA_W-1:0] boot_datai,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [DATA_W-1:0] MAX_N = DATA_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE   = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, words_q, words_d;
    logic [DATA_W-1:0] sum_q, sum_d, datai_q, datai_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              web_q, web_d, up_q, up_d, rdy_q, rdy_d;
    logic              done_q, done_d, err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic              busy, beat_accept, pack_clear, word_valid;
    logic [DATA_W-1:0] word;

    assign busy        = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CSUM);
    // abort wins over a beat in the same cycle, so that beat never reaches the packer.
    assign beat_accept = in_valid & rdy_q & ~abort;
    assign pack_clear  = (start & ~busy) | abort;

    boot_word_packer #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pack_clear),
        .beat_valid (beat_accept),
        .beat_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        sum_d   = sum_q;
        datai_d = datai_q;
        addr_d  = addr_q;
        web_d   = 1'b1;
        up_d    = up_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;

        if (busy && abort) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_ABORT;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_d = ST_HDR;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        code_d  = ERR_NONE;
                        words_d = '0;
                        sum_d   = '0;
                        up_d    = 1'b1;
                    end
                end
                ST_HDR: begin
                    if (word_valid) begin
                        if (word == '0 || word > MAX_N) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                            code_d  = ERR_LEN;
                        end else begin
                            len_d   = word[ADDR_W:0];
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_valid) begin
                        web_d   = 1'b0;
                        addr_d  = BASE + words_q[ADDR_W-1:0];
                        datai_d = word;
                        words_d = words_q + ONE;
                        sum_d   = sum_q + word;
                        if (words_q + ONE == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (word_valid) begin
                        if (word == sum_q) begin
                            state_d = ST_DONE;
                            up_d    = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                            code_d  = ERR_CSUM;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        rdy_d = (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_CSUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            words_q <= '0;
            sum_q   <= '0;
            datai_q <= '0;
            addr_q  <= '0;
            web_q   <= 1'b1;
            up_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            sum_q   <= sum_d;
            datai_q <= datai_d;
            addr_q  <= addr_d;
            web_q   <= web_d;
            up_q    <= up_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign in_ready     = rdy_q;
    assign boot_up      = up_q;
    assign boot_web     = web_q;
    assign boot_addr    = addr_q;
    assign boot_datai   = datai_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = code_q;
    assign words_loaded = words_q;

endmodule
